// File: rtl/store_merge_unit_pkg.sv
// Shared memory-stage types: access sizes, store FSM states and the alignment rule.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } mem_size_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } store_state_t;

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lsb);
        case (size)
            HALF:    return lsb[0];
            WORD:    return lsb != 2'b00;
            ILLEGAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/store_merge_unit_if.sv
// Request handshake plus word-wide RAM port of the store merge unit.
interface store_merge_unit_if #(parameter int ADDR_W = 32);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              done;
    logic              misalign;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rdata,
        output req_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, done, misalign
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rdata,
        input  req_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, done, misalign
    );

endinterface

// File: rtl/store_merge_unit_lane_merge.sv
// Combinational lane merge: drops a right-justified byte/half into its little-endian slot.
module store_lane_merge
    import mips_mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  mem_size_t   size,
    input  logic [1:0]  lsb,
    output logic [31:0] new_word
);

    always_comb begin
        new_word = old_word;
        case (size)
            BYTE:    new_word[{lsb, 3'b000} +: 8]     = data[7:0];
            HALF:    new_word[{lsb[1], 4'b0000} +: 16] = data[15:0];
            WORD:    new_word = data;
            default: new_word = old_word;
        endcase
    end

endmodule

// File: rtl/store_merge_unit.sv
// Store path of the memory stage: full-word writes go straight out, sub-word
// stores do read-modify-write on a RAM without byte enables.
module store_merge_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic               clk,
    input logic               rst,
    store_merge_unit_if.slave bus
);

    store_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    mem_size_t         size_q, size_d;
    logic [31:0]       merged_q, merged_d;

    logic              req_ready, mem_rd_en, mem_wr_en, done, misalign;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       lane_word;
    logic [ADDR_W-1:0] word_addr;

    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    store_lane_merge u_lane_merge (
        .old_word (bus.mem_rdata),
        .data     (data_q),
        .size     (size_q),
        .lsb      (addr_q[1:0]),
        .new_word (lane_word)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        size_d    = size_q;
        merged_d  = merged_q;
        req_ready = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 1'b0;
        misalign  = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    data_d = bus.req_data;
                    size_d = mem_size_t'(bus.req_size);
                    if (is_misaligned(mem_size_t'(bus.req_size), bus.req_addr[1:0]))
                        state_d = ERR;
                    else if (mem_size_t'(bus.req_size) == WORD)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                mem_rd_en = 1'b1;
                mem_addr  = word_addr;
                state_d   = MERGE;
            end
            MERGE: begin
                merged_d = lane_word;
                state_d  = WRITE;
            end
            WRITE: begin
                mem_wr_en = 1'b1;
                mem_addr  = word_addr;
                mem_wdata = (size_q == WORD) ? data_q : merged_q;
                done      = 1'b1;
                state_d   = IDLE;
            end
            ERR: begin
                misalign = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset silences every output, so a store caught in flight never writes.
        if (rst) begin
            req_ready = 1'b0;
            mem_rd_en = 1'b0;
            mem_wr_en = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            done      = 1'b0;
            misalign  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            size_q   <= BYTE;
            merged_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            size_q   <= size_d;
            merged_q <= merged_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.mem_rd_en = mem_rd_en;
    assign bus.mem_wr_en = mem_wr_en;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.done      = done;
    assign bus.misalign  = misalign;

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: behavioural RAM, shadow memory model and a queue of expected writes.
module tb_store_merge_unit;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] exp_mem [0:63];
    logic [31:0] ram     [0:63];

    store_merge_unit_if #(.ADDR_W(32)) bus ();

    store_merge_unit #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM without byte enables, one-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr[7:2]];
        if (bus.mem_wr_en) ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] d,
                                                input logic [1:0] s, input logic [1:0] lsb);
        logic [31:0] m;
        int          sh;
        if (s == 2'b00) begin sh = 8 * lsb;     m = 32'h0000_00FF << sh; end
        else            begin sh = 16 * lsb[1]; m = 32'h0000_FFFF << sh; end
        return (old & ~m) | ((d << sh) & m);
    endfunction

    function automatic bit model_mis(input logic [1:0] s, input logic [1:0] lsb);
        return (s == 2'b11) || (s == 2'b01 && lsb[0]) || (s == 2'b10 && lsb != 2'b00);
    endfunction

    // One request end to end, checking every cycle until req_ready returns.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                            input string tag, output logic [31:0] wdata_seen);
        bit  mis;
        int  lat;
        wr_t e;
        mis        = model_mis(s, a[1:0]);
        lat        = (mis || s == 2'b10) ? 1 : 3;
        wdata_seen = '0;
        if (!mis) begin
            e.addr = {a[31:2], 2'b00};
            e.data = (s == 2'b10) ? d : model_merge(exp_mem[a[7:2]], d, s, a[1:0]);
            exp_mem[a[7:2]] = e.data;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_addr = a; bus.req_data = d; bus.req_size = s;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_before: got %b want 1", tag, bus.req_ready);
        end
        @(posedge clk);
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.req_valid = 1'b0; bus.req_addr = a ^ 32'h4; bus.req_data = ~d; bus.req_size = 2'b10;
            end
            checks++;
            if (c == lat + 1) begin
                if ({bus.req_ready, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.misalign} !== 5'b10000) begin
                    errors++; $display("FAIL %s idle_after: got rdy/rd/wr/done/mis=%b want 10000", tag,
                        {bus.req_ready, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.misalign});
                end
            end else if (mis) begin
                if ({bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.misalign, bus.mem_addr} !== {4'b0001, 32'h0}) begin
                    errors++; $display("FAIL %s misalign: got rd/wr/done/mis=%b addr=%h want 0001 addr=0", tag,
                        {bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.misalign}, bus.mem_addr);
                end
            end else if (c == lat) begin
                wdata_seen = bus.mem_wdata;
                if ({bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.misalign} !== 4'b0110) begin
                    errors++; $display("FAIL %s write_strobes: got rd/wr/done/mis=%b want 0110", tag,
                        {bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.misalign});
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL %s scoreboard: got write %h@%h want none", tag, bus.mem_wdata, bus.mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.mem_addr, bus.mem_wdata} !== {e.addr, e.data}) begin
                        errors++; $display("FAIL %s write_data: got %h@%h want %h@%h", tag,
                            bus.mem_wdata, bus.mem_addr, e.data, e.addr);
                    end
                end
            end else if (c == 1) begin
                if ({bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr} !== {2'b10, a[31:2], 2'b00}) begin
                    errors++; $display("FAIL %s read: got rd/wr=%b addr=%h want 10 addr=%h", tag,
                        {bus.mem_rd_en, bus.mem_wr_en}, bus.mem_addr, {a[31:2], 2'b00});
                end
            end else begin
                if ({bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.mem_addr} !== {3'b000, 32'h0}) begin
                    errors++; $display("FAIL %s merge_quiet: got rd/wr/done=%b addr=%h want 000 addr=0", tag,
                        {bus.mem_rd_en, bus.mem_wr_en, bus.done}, bus.mem_addr);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({bus.req_ready, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.misalign, bus.mem_addr, bus.mem_wdata} !== '0) begin
                errors++; $display("FAIL reset_outputs: got rdy=%b rd=%b wr=%b addr=%h wdata=%h want all 0",
                    bus.req_ready, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wdata);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release: got ready=%b want 1", bus.req_ready);
        end
    endtask

    task automatic test_word();
        logic [31:0] w;
        do_store(32'h10, 32'hDEAD_BEEF, 2'b10, "sw", w);
        checks++;
        if (w !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL sw_value: got %h want deadbeef", w);
        end
    endtask

    task automatic test_byte();
        logic [31:0] w;
        do_store(32'h10, 32'h1122_3344, 2'b10, "seed10", w);
        do_store(32'h13, 32'h0000_00AB, 2'b00, "sb", w);
        checks++;
        if (w !== 32'hAB22_3344) begin
            errors++; $display("FAIL sb_value: got %h want ab223344", w);
        end
    endtask

    task automatic test_half();
        logic [31:0] w;
        do_store(32'h20, 32'h1122_3344, 2'b10, "seed20", w);
        do_store(32'h22, 32'h0000_CAFE, 2'b01, "sh_hi", w);
        checks++;
        if (w !== 32'hCAFE_3344) begin
            errors++; $display("FAIL sh_hi_value: got %h want cafe3344", w);
        end
        do_store(32'h20, 32'h1122_3344, 2'b10, "reseed20", w);
        do_store(32'h20, 32'hFFFF_CAFE, 2'b01, "sh_lo", w);
        checks++;
        if (w !== 32'h1122_CAFE) begin
            errors++; $display("FAIL sh_lo_value: got %h want 1122cafe", w);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] w;
        do_store(32'h21, 32'h0000_1234, 2'b01, "mis_sh", w);
        do_store(32'h12, 32'h1234_5678, 2'b10, "mis_sw", w);
        do_store(32'h10, 32'h1234_5678, 2'b11, "mis_ill", w);
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        do_store(32'h30, 32'h5566_7788, 2'b10, "seed30", w);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_addr = 32'h31; bus.req_data = 32'h99; bus.req_size = 2'b00;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.mem_rd_en !== 1'b1) begin
            errors++; $display("FAIL rstmid_read: got rd=%b want 1", bus.mem_rd_en);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({bus.req_ready, bus.mem_wr_en, bus.done} !== 3'b000) begin
                errors++; $display("FAIL rstmid_held: got rdy/wr/done=%b want 000",
                    {bus.req_ready, bus.mem_wr_en, bus.done});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.mem_wr_en} !== 2'b10) begin
            errors++; $display("FAIL rstmid_release: got rdy/wr=%b want 10", {bus.req_ready, bus.mem_wr_en});
        end
        do_store(32'h30, 32'h0000_0011, 2'b00, "after_rst", w);
        checks++;
        if (w !== 32'h5566_7711) begin
            errors++; $display("FAIL rstmid_ram: got %h want 55667711", w);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        wr_t         e;
        int          d1, d2, nd;
        do_store(32'h10, 32'h1122_3344, 2'b10, "seed_b2b", w);
        e.addr = 32'h10; e.data = model_merge(exp_mem[4], 32'hAB, 2'b00, 2'b00);
        exp_mem[4] = e.data; exp_q.push_back(e);
        e.addr = 32'h10; e.data = model_merge(exp_mem[4], 32'hCD, 2'b00, 2'b01);
        exp_mem[4] = e.data; exp_q.push_back(e);
        d1 = 0; d2 = 0; nd = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_addr = 32'h10; bus.req_data = 32'hAB; bus.req_size = 2'b00;
        @(posedge clk);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) begin bus.req_addr = 32'h11; bus.req_data = 32'hCD; end
            if (i == 4) begin
                checks++;
                if (bus.req_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_ready: got %b want 1 at N+4", bus.req_ready);
                end
            end
            if (i == 5) bus.req_valid = 1'b0;
            if (bus.done === 1'b1) begin
                nd++;
                if (nd == 1) d1 = i; else d2 = i;
                w = bus.mem_wdata;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_scoreboard: got write %h want none", bus.mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.mem_addr, bus.mem_wdata} !== {e.addr, e.data}) begin
                        errors++; $display("FAIL b2b_write: got %h@%h want %h@%h",
                            bus.mem_wdata, bus.mem_addr, e.data, e.addr);
                    end
                end
            end
        end
        checks++;
        if (nd != 2 || d1 != 3 || d2 != 7) begin
            errors++; $display("FAIL b2b_timing: got %0d dones at N+%0d,N+%0d want 2 at N+3,N+7", nd, d1, d2);
        end
        checks++;
        if (w !== 32'h1122_CDAB) begin
            errors++; $display("FAIL b2b_value: got %h want 1122cdab", w);
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_data = '0; bus.req_size = 2'b00;
        for (int i = 0; i < 64; i++) exp_mem[i] = '0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Store-path counterpart of the load sign extender in the MIPS memory stage. The extender widens 16-bit values to 32 bits; this unit narrows register data into byte and halfword slots and writes them back. It accepts `sw`/`sh`/`sb` requests, writes full words directly, and performs read-modify-write on a word-wide synchronous data RAM that has no byte enables. A fixed-latency FSM with a valid/ready request handshake flags misaligned requests.

## Interface
- `ADDR_W`, default 32: byte-address width; the RAM address is `{addr[ADDR_W-1:2], 2'b00}`.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in, 1: rising-edge clock.
- `rst` in, 1: synchronous, active-high reset.
- `req_valid` in, 1: store request present.
- `req_ready` out, 1: unit can accept; high only in IDLE with `rst`=0.
- `req_addr` in, ADDR_W: byte address.
- `req_data` in, 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `req_size` in, 2: 00 byte, 01 half, 10 word, 11 illegal.
- `mem_rd_en` out, 1: RAM read strobe; data is returned the following cycle.
- `mem_wr_en` out, 1: RAM write strobe.
- `mem_addr` out, ADDR_W: word-aligned RAM address.
- `mem_wdata` out, 32: RAM write data.
- `mem_rdata` in, 32: RAM read data, valid the cycle after `mem_rd_en`.
- `done` out, 1: one-cycle pulse coincident with the write.
- `misalign` out, 1: one-cycle pulse for a rejected request.

## Operation
- FSM states: IDLE, READ, MERGE, WRITE, ERR.
- **Accept:** a request is accepted on the edge where `req_valid && req_ready`. At that edge the unit latches `req_addr`, `req_data` and `req_size`.
- **Alignment check:** `req_size`=01 with `addr[0]`=1, `req_size`=10 with `addr[1:0]`≠0, and `req_size`=11 are all misaligned.
- **Transitions out of IDLE on accept:**
  - misaligned → ERR
  - word → WRITE
  - byte or half → READ
- **READ:** `mem_rd_en`=1, `mem_addr`=aligned address. Next state MERGE.
- **MERGE:** the unit registers the merged word from `mem_rdata`. Next state WRITE.
- **Merge rule (little-endian lanes):**
  - byte k = `addr[1:0]` replaces bits [8k+7:8k] with `req_data[7:0]`
  - half h = `addr[1]` replaces bits [16h+15:16h] with `req_data[15:0]`
  - all other bits come from `mem_rdata`.
- **WRITE:** `mem_wr_en`=1, `mem_addr`=aligned address, `done`=1. `mem_wdata` is the merged word for sub-word stores and `req_data` for word stores. Next state IDLE.
- **ERR:** `misalign`=1, with no memory strobes. Next state IDLE.
- **Output quiescence:** outside their states, `mem_rd_en`, `mem_wr_en`, `done` and `misalign` are 0, and `mem_addr`/`mem_wdata` read 0.
- **Reset:** `rst` forces IDLE and clears all latched registers, from any state. A store interrupted mid-operation is abandoned and no write is issued.
- **Reset values of outputs:** `req_ready`=0 while `rst`=1; all other outputs 0.

## Timing
- Accept edge = cycle N.
- Word store: WRITE/`done` in N+1; `req_ready` high again in N+2.
- Sub-word store: READ in N+1, MERGE in N+2, WRITE/`done` in N+3; `req_ready` high again in N+4.
- Misaligned request: `misalign` in N+1; `req_ready` high again in N+2.
- Back-to-back requests: a held `req_valid` is accepted on the first IDLE cycle. There is no overlap and no queueing.
- Request inputs are sampled only at the accept edge; changes after accept are ignored.
- `rst` asserted during MERGE or READ: the next cycle is IDLE with all strobes 0, and `mem_wr_en` never pulses for that request.

## Structure
- Package `mips_mem_pkg` holds:
  - enum `mem_size_t` (BYTE, HALF, WORD, ILLEGAL)
  - enum `store_state_t` (IDLE, READ, MERGE, WRITE, ERR)
  - function `is_misaligned(size, addr[1:0])`.
- Sub-module `store_lane_merge` is purely combinational: `(old_word, data, size, addr[1:0])` → `new_word`. It is reusable by the cache write path.
- Top level contains the FSM, the request latches and the merged-word register.

## Test plan
- **Word store:** `sw` addr 0x10, data 0xDEADBEEF → N+1: `mem_wr_en`=1, `mem_addr`=0x10, `mem_wdata`=0xDEADBEEF, `done`=1. `mem_rd_en` never asserts.
- **Byte store:** `sb` addr 0x13, data 0x000000AB, RAM holds 0x11223344 → N+1: read at 0x10; N+3: write 0xAB223344 at 0x10 with `done`.
- **Halfword store:** `sh` addr 0x22, data 0x0000CAFE, RAM holds 0x11223344 → N+3: write 0xCAFE3344 at 0x20. Repeating at addr 0x20 gives 0x1122CAFE.
- **Misaligned store:** `sh` addr 0x21 → N+1: `misalign`=1, no strobes; N+2: `req_ready`=1. The same check with `sw` addr 0x12 and with `req_size`=11 gives the same result.
- **Reset mid-operation:** `sb` accepted, `rst` asserted in MERGE → `mem_wr_en` stays 0 throughout. `req_ready`=0 while `rst`=1, and returns to 1 the cycle after `rst` deasserts.
- **Back-to-back:** `req_valid` held across two `sb` requests to 0x10 and 0x11 → `done` pulses 4 cycles apart. The second write merges over the first write's result.
